// File: rtl/ddr2_host_pkg.sv
// ddr2_host_pkg
// Shared definitions for the host command intake path: host command
// encoding, default queue depths, burst-length unit, the command-queue
// entry layout and the intake FSM state type.
package ddr2_host_pkg;

    localparam int CQ_DEPTH_DEF = 16;
    localparam int DQ_DEPTH_DEF = 64;
    localparam int BURST_UNIT   = 8;
    // Wide enough for the largest remaining-beat count (4*BURST_UNIT-1).
    localparam int BEAT_W       = 5;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_SCR  = 3'd1,
        CMD_SCW  = 3'd2,
        CMD_BLR  = 3'd3,
        CMD_BLW  = 3'd4,
        CMD_ATR  = 3'd5,
        CMD_ATW  = 3'd6,
        CMD_NOP7 = 3'd7
    } cmd_e;

    typedef struct packed {
        cmd_e        cmd;
        logic [1:0]  sz;
        logic [2:0]  op;
        logic [24:0] addr;
    } cq_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_BLK_DATA
    } intake_state_e;

    // Words in one block transfer: 8, 16, 24 or 32.
    function automatic logic [5:0] burst_words(input logic [1:0] sz);
        return 6'(BURST_UNIT) * (6'(sz) + 6'd1);
    endfunction

endpackage

// File: rtl/host_cmd_intake_if.sv
// host_cmd_intake_if
// Bundles the host-side command/data inputs with the flow-control outputs,
// and the scheduler-side queue heads with their pop strobes.
//   slave  : used by host_cmd_intake
//   master : used by whatever drives the host side and consumes the queues
interface host_cmd_intake_if
    import ddr2_host_pkg::*;
#(
    parameter int DQ_DEPTH = DQ_DEPTH_DEF
);
    localparam int FC_W = $clog2(DQ_DEPTH + 1);

    // Host side
    logic              init_done;
    logic [2:0]        cmd;
    logic [1:0]        sz;
    logic [2:0]        op;
    logic [24:0]       addr;
    logic [15:0]       din;
    logic              notfull;
    logic [FC_W-1:0]   fillcount;

    // Scheduler side
    logic              cq_valid;
    logic [2:0]        cq_cmd;
    logic [1:0]        cq_sz;
    logic [2:0]        cq_op;
    logic [24:0]       cq_addr;
    logic              cq_pop;
    logic              dq_valid;
    logic [15:0]       dq_data;
    logic              dq_pop;

    modport slave (
        input  init_done, cmd, sz, op, addr, din, cq_pop, dq_pop,
        output notfull, fillcount,
        output cq_valid, cq_cmd, cq_sz, cq_op, cq_addr, dq_valid, dq_data
    );

    modport master (
        output init_done, cmd, sz, op, addr, din, cq_pop, dq_pop,
        input  notfull, fillcount,
        input  cq_valid, cq_cmd, cq_sz, cq_op, cq_addr, dq_valid, dq_data
    );

endinterface

// File: rtl/host_cmd_intake_fifo.sv
// sync_fifo
// Single-clock first-word-fall-through FIFO with an occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe / data
//   pop        : consume head (ignored when empty)
//   dout       : head word, forced to 0 while empty
//   valid      : head valid
//   count      : occupancy 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_eff, pop_eff;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_eff  = pop && (count_reg != '0);
    assign push_eff = push && ((count_reg != CW'(DEPTH)) || pop_eff);

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_eff)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head is read asynchronously so a word pushed on one edge is visible
    // right after it; masking with valid keeps stale words off the bus.
    assign valid = (count_reg != '0);
    assign dout  = valid ? mem[rd_ptr_reg] : '0;
    assign count = count_reg;

endmodule

// File: rtl/host_cmd_intake.sv
// host_cmd_intake
// Accepts host commands into a command queue and write data into a data
// queue. Block writes stay in BLK_DATA until every beat has been taken.
//   clk   : clock (rising edge)
//   rst_n : asynchronous active-low reset
//   bus   : host inputs, NOTFULL/FILLCOUNT flow control, queue heads/pops
module host_cmd_intake
    import ddr2_host_pkg::*;
#(
    parameter int CQ_DEPTH = CQ_DEPTH_DEF,
    parameter int DQ_DEPTH = DQ_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    host_cmd_intake_if.slave  bus
);
    localparam int CQ_CW = $clog2(CQ_DEPTH + 1);
    localparam int DQ_CW = $clog2(DQ_DEPTH + 1);

    intake_state_e     state_reg, state_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic              cq_push, dq_push;
    logic              cspace, dspace;
    logic [CQ_CW-1:0]  cq_count;
    logic [DQ_CW-1:0]  dq_count;
    cq_entry_t         cq_in, cq_head;

    // Space flags come from registered counts only, so a pop in the same
    // cycle does not open room until the next cycle.
    assign cspace = (cq_count != CQ_CW'(CQ_DEPTH));
    assign dspace = (dq_count <= DQ_CW'(DQ_DEPTH - 1));

    assign cq_in = '{cmd: cmd_e'(bus.cmd), sz: bus.sz, op: bus.op, addr: bus.addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        cq_push    = 1'b0;
        dq_push    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.init_done) begin
                    case (cmd_e'(bus.cmd))
                        CMD_SCR, CMD_BLR: begin
                            cq_push = cspace;
                        end
                        CMD_SCW, CMD_ATR, CMD_ATW: begin
                            cq_push = cspace && dspace;
                            dq_push = cspace && dspace;
                        end
                        CMD_BLW: begin
                            if (cspace && dspace) begin
                                cq_push    = 1'b1;
                                dq_push    = 1'b1;
                                // First beat rides with the command.
                                beat_next  = BEAT_W'(burst_words(bus.sz) - 6'd1);
                                state_next = ST_BLK_DATA;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_BLK_DATA: begin
                // Host fields other than DIN are ignored mid-burst.
                if (dspace) begin
                    dq_push   = 1'b1;
                    beat_next = beat_reg - 1'b1;
                    if (beat_reg == BEAT_W'(1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    sync_fifo #(.WIDTH($bits(cq_entry_t)), .DEPTH(CQ_DEPTH)) u_cmd_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cq_push),
        .din   (cq_in),
        .pop   (bus.cq_pop),
        .dout  (cq_head),
        .valid (bus.cq_valid),
        .count (cq_count)
    );

    sync_fifo #(.WIDTH(16), .DEPTH(DQ_DEPTH)) u_data_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (dq_push),
        .din   (bus.din),
        .pop   (bus.dq_pop),
        .dout  (bus.dq_data),
        .valid (bus.dq_valid),
        .count (dq_count)
    );

    assign bus.notfull   = cspace;
    assign bus.fillcount = dq_count;
    assign bus.cq_cmd    = cq_head.cmd;
    assign bus.cq_sz     = cq_head.sz;
    assign bus.cq_op     = cq_head.op;
    assign bus.cq_addr   = cq_head.addr;

endmodule
